// File: rtl/bench_pkg.sv
// bench_pkg: shared definitions for the benchmark campaign sequencer.
//   - state_t    : campaign FSM states
//   - NUM_COND   : number of measured conditions (engine count lanes)
//   - SUM_PAD    : extra bits on each sum so 255 runs cannot overflow
//   - COND_*     : condition codes, also the value reported on `winner`
package bench_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_START,
        ST_WAIT,
        ST_CAPTURE,
        ST_GAP,
        ST_EVAL
    } state_t;

    localparam int unsigned NUM_COND = 4;
    localparam int unsigned SUM_PAD  = 8;

    localparam logic [1:0] COND_BASE2  = 2'd0;
    localparam logic [1:0] COND_BASE10 = 2'd1;
    localparam logic [1:0] COND_BASE12 = 2'd2;
    localparam logic [1:0] COND_ROUTER = 2'd3;

endpackage

// File: rtl/bench_accum.sv
// bench_accum: per-condition accumulator for one benchmark condition.
// Holds the running sum of captured counts and, when BENCH_SEQ_MIN_EN is
// defined, the minimum single-run count. Without the macro the minimum
// register and comparator are not built and min_cnt is tied to all-ones.
//
// Ports:
//   sysclk    in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   clear     in   zero the sum, set the minimum to all-ones
//   capture   in   add count to the sum, fold count into the minimum
//   count     in   CNT_W  per-run cycle count from the engine
//   sum       out  SUM_W  registered running sum
//   sum_next  out  SUM_W  sum + count (value the sum takes on capture)
//   min_cnt   out  CNT_W  registered minimum (all-ones when disabled)
module bench_accum
    import bench_pkg::*;
#(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned SUM_W = CNT_W + SUM_PAD
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             capture,
    input  logic [CNT_W-1:0] count,
    output logic [SUM_W-1:0] sum,
    output logic [SUM_W-1:0] sum_next,
    output logic [CNT_W-1:0] min_cnt
);

    assign sum_next = sum + SUM_W'(count);

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (capture) begin
            sum <= sum_next;
        end
    end

`ifdef BENCH_SEQ_MIN_EN
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            min_cnt <= '1;
        end else if (clear) begin
            min_cnt <= '1;
        end else if (capture && (count < min_cnt)) begin
            min_cnt <= count;
        end
    end
`else
    assign min_cnt = '1;
`endif

endmodule

// File: rtl/bench_sequencer.sv
// bench_sequencer: campaign controller in front of bench_engine.
// On `trigger` it runs the engine NUM_RUNS times, each run started with a
// one-cycle eng_start and finished by a rising edge of eng_done (guarded by a
// watchdog), accumulates the four per-condition counts, then reports the
// per-condition sums/minima and the condition with the smallest sum.
// Optional feature macro: BENCH_SEQ_MIN_EN (builds the minimum trackers).
//
// Ports:
//   sysclk         in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   trigger        in   single-cycle campaign request (ignored while busy)
//   abort          in   cancel a campaign in progress
//   eng_start      out  single-cycle engine start pulse
//   eng_done       in   engine done level
//   eng_t          in   4*CNT_W  {t_cond3, t_cond2, t_cond1, t_cond0}
//   busy           out  campaign in progress
//   campaign_done  out  single-cycle pulse at campaign end (normal or timeout)
//   run_idx        out  8        current run, 0-based
//   sum_flat       out  4*SUM_W  per-condition sums
//   min_flat       out  4*CNT_W  per-condition minima
//   winner         out  2        condition with the smallest sum
//   timeout_err    out  watchdog expiry ended the last campaign
//   led_onehot     out  4        1 << winner after a successful campaign
module bench_sequencer
    import bench_pkg::*;
#(
    parameter int unsigned NUM_RUNS       = 8,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1048576,
    parameter int unsigned GAP_CYCLES     = 16
) (
    input  logic                        sysclk,
    input  logic                        rst_n,
    input  logic                        trigger,
    input  logic                        abort,
    output logic                        eng_start,
    input  logic                        eng_done,
    input  logic [4*CNT_W-1:0]          eng_t,
    output logic                        busy,
    output logic                        campaign_done,
    output logic [7:0]                  run_idx,
    output logic [4*(CNT_W+SUM_PAD)-1:0] sum_flat,
    output logic [4*CNT_W-1:0]          min_flat,
    output logic [1:0]                  winner,
    output logic                        timeout_err,
    output logic [3:0]                  led_onehot
);

    localparam int unsigned SUM_W = CNT_W + SUM_PAD;
    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    state_t           state;
    logic [WD_W-1:0]  wd;
    logic [GAP_W-1:0] gap_cnt;
    logic             eng_done_q;
    logic             done_rise;

    logic             acc_clear;
    logic             acc_capture;
    logic [SUM_W-1:0] sum_next [NUM_COND];

    logic [1:0]       w01;
    logic [1:0]       w23;
    logic [1:0]       win_next;
    logic [SUM_W-1:0] m01;
    logic [SUM_W-1:0] m23;

    assign done_rise   = eng_done & ~eng_done_q;
    assign acc_clear   = (state == ST_CLEAR)   && !abort;
    assign acc_capture = (state == ST_CAPTURE) && !abort;

    for (genvar c = 0; c < NUM_COND; c++) begin : g_cond
        bench_accum #(
            .CNT_W (CNT_W),
            .SUM_W (SUM_W)
        ) u_accum (
            .sysclk   (sysclk),
            .rst_n    (rst_n),
            .clear    (acc_clear),
            .capture  (acc_capture),
            .count    (eng_t[c*CNT_W +: CNT_W]),
            .sum      (sum_flat[c*SUM_W +: SUM_W]),
            .sum_next (sum_next[c]),
            .min_cnt  (min_flat[c*CNT_W +: CNT_W])
        );
    end

    // Winner tree over the post-capture sums so the result is ready in the
    // EVAL cycle. Strict '<' keeps the lower index on ties at every level,
    // and the left pair always holds the lower indices.
    always_comb begin
        w01 = COND_BASE2;
        m01 = sum_next[0];
        if (sum_next[1] < sum_next[0]) begin
            w01 = COND_BASE10;
            m01 = sum_next[1];
        end
        w23 = COND_BASE12;
        m23 = sum_next[2];
        if (sum_next[3] < sum_next[2]) begin
            w23 = COND_ROUTER;
            m23 = sum_next[3];
        end
        win_next = w01;
        if (m23 < m01) begin
            win_next = w23;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            eng_start     <= 1'b0;
            busy          <= 1'b0;
            campaign_done <= 1'b0;
            timeout_err   <= 1'b0;
            run_idx       <= '0;
            winner        <= '0;
            led_onehot    <= '0;
            wd            <= '0;
            gap_cnt       <= '0;
            eng_done_q    <= 1'b0;
        end else begin
            eng_done_q    <= eng_done;
            eng_start     <= 1'b0;
            campaign_done <= 1'b0;

            if (abort && (state != ST_IDLE)) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (trigger && !abort) begin
                            state <= ST_CLEAR;
                            busy  <= 1'b1;
                        end
                    end

                    ST_CLEAR: begin
                        run_idx     <= '0;
                        timeout_err <= 1'b0;
                        led_onehot  <= '0;
                        wd          <= '0;
                        eng_start   <= 1'b1;
                        state       <= ST_START;
                    end

                    // The watchdog is zeroed on entry to START and counts the
                    // START cycle itself, so expiry lands TIMEOUT_CYCLES
                    // cycles after the eng_start pulse.
                    ST_START: begin
                        wd    <= WD_W'(1);
                        state <= ST_WAIT;
                    end

                    ST_WAIT: begin
                        if (done_rise) begin
                            state <= ST_CAPTURE;
                        end else if (wd >= WD_W'(TIMEOUT_CYCLES - 1)) begin
                            timeout_err   <= 1'b1;
                            campaign_done <= 1'b1;
                            busy          <= 1'b0;
                            state         <= ST_IDLE;
                        end else begin
                            wd <= wd + WD_W'(1);
                        end
                    end

                    // Results and the done pulse are registered on the way
                    // into EVAL so they are visible during the EVAL cycle.
                    ST_CAPTURE: begin
                        if (run_idx == 8'(NUM_RUNS - 1)) begin
                            winner        <= win_next;
                            led_onehot    <= 4'b0001 << win_next;
                            campaign_done <= 1'b1;
                            state         <= ST_EVAL;
                        end else begin
                            run_idx <= run_idx + 8'd1;
                            gap_cnt <= '0;
                            state   <= ST_GAP;
                        end
                    end

                    ST_GAP: begin
                        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                            wd        <= '0;
                            eng_start <= 1'b1;
                            state     <= ST_START;
                        end else begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                    end

                    ST_EVAL: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end

                    default: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
